hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_detect.sv | 31 +++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//   state_e     : hazard FSM state encoding (RUN / DMEM_WAIT / IMEM_WAIT)
//   REG_W_DEF   : default register-number width
//   CNT_W_DEF   : default stall-counter width
//   NOP_INSTR   : instruction word the IF/ID register loads on a flush
package hazard_pkg;

  localparam int          REG_W_DEF = 5;
  localparam int          CNT_W_DEF = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect -- combinational load-use hazard detector.
//   id_rs_i / id_rt_i : source registers of the instruction in ID
//   id_uses_rt_i      : ID instruction actually reads rt
//   ex_memread_i      : instruction in EX is a load
//   ex_rd_i           : destination of the EX instruction
//   load_use_o        : ID must wait one cycle for the load result
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             load_use_o
);

  logic rd_nonzero;
  logic rs_hit;
  logic rt_hit;

  // Register 0 is hard-wired to zero, so a load targeting it never
  // produces a value anyone has to wait for.
  assign rd_nonzero = (ex_rd_i != '0);
  assign rs_hit     = (ex_rd_i == id_rs_i);
  assign rt_hit     = id_uses_rt_i && (ex_rd_i == id_rt_i);
  assign load_use_o = ex_memread_i && rd_nonzero && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline stall/flush controller.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   id_rs_i, id_rt_i,
//   id_uses_rt_i        : operands of the instruction in ID
//   ex_memread_i,
//   ex_rd_i             : load in EX and its destination
//   redirect_i          : taken branch / jump resolved in ID (pulse)
//   imem_stall_i,
//   dmem_stall_i        : memories not ready this cycle
//   pc_stall_o .. ex_mem_stall_o : per-stage hold / flush controls
//   stall_cnt_o         : saturating count of cycles with the PC held
// Controls are combinational from the current inputs plus the pending
// redirect flag, so they act in the same cycle as the hazard.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             redirect_i,
  input  logic             imem_stall_i,
  input  logic             dmem_stall_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             load_use;
  state_e           state_q, state_d;
  logic             redirect_pend_q, redirect_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .load_use_o   (load_use)
  );

  always_comb begin
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_stall_o  = 1'b0;
    redirect_pend_d = redirect_pend_q;

    if (dmem_stall_i)      state_d = ST_DMEM_WAIT;
    else if (imem_stall_i) state_d = ST_IMEM_WAIT;
    else                   state_d = ST_RUN;

    if (rst_i) begin
      // all controls stay low while reset is held
    end else if (dmem_stall_i) begin
      // Whole pipeline frozen; remember a redirect so it is not lost.
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      id_ex_stall_o   = 1'b1;
      ex_mem_stall_o  = 1'b1;
      redirect_pend_d = redirect_pend_q | redirect_i;
    end else if (imem_stall_i) begin
      // No fetched word this cycle: hold PC and feed a NOP into IF/ID.
      pc_stall_o      = 1'b1;
      if_id_flush_o   = 1'b1;
      redirect_pend_d = redirect_pend_q | redirect_i;
    end else if (load_use) begin
      // A redirect seen now belongs to the held ID instruction, which
      // re-issues next cycle, so it is dropped; an older pending one stays.
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      if_id_flush_o   = redirect_i | redirect_pend_q;
      redirect_pend_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_RUN;
      redirect_pend_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      // Catch a corrupted state register in simulation.
      assert (state_q inside {ST_RUN, ST_DMEM_WAIT, ST_IMEM_WAIT});
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_uses_rt, ex_memread, redirect, imem_stall, dmem_stall;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [15:0] stall_cnt;
  logic [5:0] outs;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        ref_pend;
  logic [15:0] ref_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .ex_memread_i   (ex_memread),
    .ex_rd_i        (ex_rd),
    .redirect_i     (redirect),
    .imem_stall_i   (imem_stall),
    .dmem_stall_i   (dmem_stall),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_stall_o  (id_ex_stall),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_stall_o (ex_mem_stall),
    .stall_cnt_o    (stall_cnt)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_DMEM  = 6'b110101;
  localparam logic [5:0] O_IMEM  = 6'b101000;
  localparam logic [5:0] O_LU    = 6'b110010;
  localparam logic [5:0] O_FLUSH = 6'b001000;

  function automatic logic spec_load_use();
    return ex_memread && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // Expected controls from the priority rules: dmem > imem > load-use > redirect.
  function automatic logic [5:0] expected();
    if (rst)                         return O_IDLE;
    if (dmem_stall)                  return O_DMEM;
    if (imem_stall)                  return O_IMEM;
    if (spec_load_use())             return O_LU;
    if (redirect || ref_pend)        return O_FLUSH;
    return O_IDLE;
  endfunction

  task automatic drive(input logic rst_v, dmem_v, imem_v, redir_v, mr_v, urt_v,
                       input logic [4:0] rd_v, rs_v, rt_v);
    @(negedge clk);
    rst = rst_v; dmem_stall = dmem_v; imem_stall = imem_v; redirect = redir_v;
    ex_memread = mr_v; id_uses_rt = urt_v; ex_rd = rd_v; id_rs = rs_v; id_rt = rt_v;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Advance the model across the coming rising edge for the applied inputs.
  task automatic advance();
    logic [5:0] e;
    e = expected();
    if (rst) begin
      ref_pend = 1'b0;
      ref_cnt  = 16'd0;
    end else begin
      if (e[5] && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
      if (dmem_stall || imem_stall) ref_pend = ref_pend | redirect;
      else if (!spec_load_use())    ref_pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    advance();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); end
    advance();
    idle();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL reset_idle got=%b exp=%b", outs, O_IDLE); end
    advance();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd1);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL load_use_outs got=%b exp=%b", outs, O_LU); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL load_use_cnt0 got=%0d exp=0", stall_cnt); end
    advance();
    idle();
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL load_use_after got=%b exp=%b", outs, O_IDLE); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL load_use_cnt1 got=%0d exp=1", stall_cnt); end
    advance();
    // rt match only counts when rt is used
    drive(0, 0, 0, 0, 1, 1, 5'd9, 5'd2, 5'd9);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL load_use_rt got=%b exp=%b", outs, O_LU); end
    advance();
    drive(0, 0, 0, 0, 1, 0, 5'd9, 5'd2, 5'd9);
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL load_use_rt_unused got=%b exp=%b", outs, O_IDLE); end
    advance();
    $display("test_load_use done");
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL zero_reg_outs got=%b exp=%b", outs, O_IDLE); end
    advance();
    idle();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL zero_reg_cnt got=%0d exp=0", stall_cnt); end
    advance();
    $display("test_zero_reg done");
  endtask

  task automatic test_dmem_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, (i == 1), 0, 0, 5'd0, 5'd0, 5'd0);
      total++; if (outs !== O_DMEM) begin bad++; $display("FAIL dmem_freeze%0d got=%b exp=%b", i, outs, O_DMEM); end
      advance();
    end
    idle();
    total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL dmem_pend_flush got=%b exp=%b", outs, O_FLUSH); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL dmem_cnt got=%0d exp=3", stall_cnt); end
    advance();
    idle();
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL dmem_pend_cleared got=%b exp=%b", outs, O_IDLE); end
    advance();
    $display("test_dmem_redirect done");
  endtask

  task automatic test_imem_loaduse();
    do_reset();
    drive(0, 0, 1, 0, 1, 0, 5'd4, 5'd4, 5'd0);
    total++; if (outs !== O_IMEM) begin bad++; $display("FAIL imem_over_lu got=%b exp=%b", outs, O_IMEM); end
    advance();
    $display("test_imem_loaduse done");
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL redirect_plain got=%b exp=%b", outs, O_FLUSH); end
    advance();
    drive(0, 0, 0, 1, 1, 0, 5'd5, 5'd5, 5'd0);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL redirect_lu got=%b exp=%b", outs, O_LU); end
    advance();
    idle();
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL redirect_not_latched got=%b exp=%b", outs, O_IDLE); end
    advance();
    // pending redirect survives a load-use cycle
    drive(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    advance();
    drive(0, 0, 0, 0, 1, 0, 5'd6, 5'd6, 5'd0);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL pend_lu got=%b exp=%b", outs, O_LU); end
    advance();
    idle();
    total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL pend_kept got=%b exp=%b", outs, O_FLUSH); end
    advance();
    $display("test_redirect done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      total++; if (outs !== expected()) begin bad++; $display("FAIL random_outs%0d got=%b exp=%b", i, outs, expected()); end
      total++; if (stall_cnt !== ref_cnt) begin bad++; $display("FAIL random_cnt%0d got=%0d exp=%0d", i, stall_cnt, ref_cnt); end
      advance();
    end
    $display("test_random done");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      advance();
    end
    drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", stall_cnt); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      advance();
    end
    idle();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    advance();
    $display("test_saturate done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    advance();
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL midrst_outs got=%b exp=%b", outs, O_IDLE); end
    advance();
    idle();
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL midrst_pend got=%b exp=%b", outs, O_IDLE); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", stall_cnt); end
    advance();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    rst = 1'b1; dmem_stall = 0; imem_stall = 0; redirect = 0;
    ex_memread = 0; id_uses_rt = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    ref_pend = 1'b0; ref_cnt = 16'd0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_dmem_redirect();
    test_imem_loaduse();
    test_redirect();
    test_random();
    test_saturate();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
